demux1to2_reg: RTL

//  Registered 1-to-2 demultiplexer: the routing counterpart of the 2:1 mux family.

---
 rtl/demux1to2_reg_pkg.sv | 18 +
 rtl/demux1to2_reg_slot.sv | 64 ++++++
 rtl/demux1to2_reg.sv | 70 +++++++
 3 files changed

// File: rtl/demux1to2_reg_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer and its benches:
// destination select codes, per-slot state encoding and the slot-ready rule.
package demux1to2_reg_pkg;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    // A slot can take a new word when it is empty or is being drained this cycle.
    function automatic logic slot_can_load(input logic valid, input logic consumer_ready);
        return ~valid | consumer_ready;
    endfunction

endpackage

// File: rtl/demux1to2_reg_slot.sv
// One-entry output holding slot: data register, EMPTY/FULL state and a
// wrapping count of words loaded since reset. The parent only asserts load
// when the slot can accept, so a load while full always coincides with a drain.
module demux_slot
    import demux1to2_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready_out,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    slot_state_t state;
    slot_state_t state_next;
    logic        drain;

    assign valid = (state == ST_FULL);
    assign drain = valid & ready_out;

    // State register for the EMPTY/FULL slot FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fill on load, empty on drain unless refilled in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (load)           state_next = ST_FULL;
            ST_FULL:  if (drain && !load) state_next = ST_EMPTY;
            default:                      state_next = ST_EMPTY;
        endcase
    end

    // Data register keeps its last word after a drain so the output stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

    // Count of words steered to this slot; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux1to2_reg.sv
// Registered 1-to-2 demultiplexer: one valid/ready producer feeding two
// independent consumers through one-entry slots, with per-port word counters.
module demux1to2_reg
    import demux1to2_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic slot_ready0;
    logic slot_ready1;
    logic accept;
    logic load0;
    logic load1;

    // Input readiness depends only on the selected slot, never on in_valid,
    // so a stalled port holds back only words addressed to it.
    always_comb begin
        slot_ready0 = slot_can_load(out0_valid, out0_ready);
        slot_ready1 = slot_can_load(out1_valid, out1_ready);
        in_ready    = (sel == SEL_OUT1) ? slot_ready1 : slot_ready0;
        accept      = in_valid & in_ready;
        load0       = accept & (sel == SEL_OUT0);
        load1       = accept & (sel == SEL_OUT1);
    end

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .din       (in),
        .ready_out (out0_ready),
        .dout      (out0),
        .valid     (out0_valid),
        .cnt       (cnt0)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .din       (in),
        .ready_out (out1_ready),
        .dout      (out1),
        .valid     (out1_valid),
        .cnt       (cnt1)
    );

endmodule
